// File: rtl/rc_cpl_realign_x8_pkg.sv
// Shared types and helpers for the 256-bit completion realigner.
package rc_cpl_realign_x8_pkg;

  typedef enum logic [1:0] {S_HDR, S_BODY, S_TAIL} state_t;

  localparam int DW_PER_BEAT = 8;
  localparam int HDR_DW      = 3;
  localparam int POISON      = 1;
  localparam int DISCONT     = 0;

  function automatic logic [31:0] dw2keep(input logic [3:0] count);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < DW_PER_BEAT; i++)
      if (4'(i) < count) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  function automatic logic [255:0] keep2mask(input logic [31:0] keep);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

endpackage

// File: rtl/rc_cpl_realign_x8.sv
// Strips the 3-DW completion header onto a sideband and shifts payload DW0
// down to output DW0, using a 5-DW carry between consecutive input beats.
module rc_cpl_realign_x8
  import rc_cpl_realign_x8_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [84:0]           s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic [3:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [95:0]           m_axis_hdr,
  output logic                  m_axis_poisoned,
  output logic                  m_axis_discontinue
);

  state_t         state, state_nxt;
  logic [159:0]   carry, carry_nxt;
  logic [2:0]     tail_dw, tail_nxt;
  logic [95:0]    hdr_nxt;
  logic [1:0]     flags, flags_nxt;
  logic [3:0]     n_dw;
  logic           load, in_rdy, accept;
  logic           emit, out_last;
  logic [255:0]   out_raw;
  logic [31:0]    out_keep;
  logic [1:0]     in_flags;
  logic           unused_ok;

  assign load          = !m_axis_tvalid || m_axis_tready;
  assign in_rdy        = load && (state != S_TAIL);
  assign accept        = s_axis_tvalid && in_rdy;
  assign s_axis_tready = {4{in_rdy}};
  assign in_flags      = {s_axis_tuser[POISON], s_axis_tuser[DISCONT]};
  assign m_axis_poisoned    = flags[1];
  assign m_axis_discontinue = flags[0];
  assign unused_ok     = ^{s_axis_tuser[84:2], s_axis_tkeep};

  always_comb begin
    n_dw = '0;
    for (int i = 0; i < DW_PER_BEAT; i++) n_dw = n_dw + 4'(s_axis_tkeep[4*i]);
  end

  always_comb begin
    state_nxt = state;
    carry_nxt = carry;
    tail_nxt  = tail_dw;
    hdr_nxt   = m_axis_hdr;
    flags_nxt = flags;
    emit      = 1'b0;
    out_raw   = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    case (state)
      S_HDR: if (accept) begin
        hdr_nxt   = s_axis_tdata[95:0];
        flags_nxt = in_flags;
        if (s_axis_tlast) begin
          emit     = 1'b1;
          out_raw  = {96'b0, s_axis_tdata[255:96]};
          out_keep = dw2keep((n_dw > 4'(HDR_DW)) ? n_dw - 4'(HDR_DW) : 4'd0);
          out_last = 1'b1;
        end else begin
          carry_nxt = s_axis_tdata[255:96];
          state_nxt = S_BODY;
        end
      end
      S_BODY: if (accept) begin
        flags_nxt = flags | in_flags;
        emit      = 1'b1;
        out_raw   = {s_axis_tdata[95:0], carry};
        if (s_axis_tlast && n_dw <= 4'(HDR_DW)) begin
          out_keep  = dw2keep(4'd5 + n_dw);
          out_last  = 1'b1;
          state_nxt = S_HDR;
        end else begin
          out_keep  = '1;
          carry_nxt = s_axis_tdata[255:96];
          if (s_axis_tlast) begin
            // Leftover dwords in the carry need one extra output beat.
            tail_nxt  = 3'(n_dw - 4'(HDR_DW));
            state_nxt = S_TAIL;
          end
        end
      end
      S_TAIL: if (load) begin
        emit      = 1'b1;
        out_raw   = {96'b0, carry};
        out_keep  = dw2keep({1'b0, tail_dw});
        out_last  = 1'b1;
        state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state         <= S_HDR;
      carry         <= '0;
      tail_dw       <= '0;
      m_axis_hdr    <= '0;
      flags         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state      <= state_nxt;
      carry      <= carry_nxt;
      tail_dw    <= tail_nxt;
      m_axis_hdr <= hdr_nxt;
      flags      <= flags_nxt;
      // Output register stage: dwords beyond tkeep are forced to zero.
      if (load) begin
        m_axis_tvalid <= emit;
        if (emit) begin
          m_axis_tdata <= out_raw & keep2mask(out_keep);
          m_axis_tkeep <= out_keep;
          m_axis_tlast <= out_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc_cpl_realign_x8.sv
// Randomized bench for rc_cpl_realign_x8 with a packet-level payload model.
module tb_rc_cpl_realign_x8;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [84:0]  user;
  } in_beat_t;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [95:0]  hdr;
    logic         pois;
    logic         disc;
  } out_beat_t;

  logic         clk = 1'b0;
  logic         user_reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [84:0]  s_axis_tuser;
  logic         s_axis_tvalid;
  logic [3:0]   s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [95:0]  m_axis_hdr;
  logic         m_axis_poisoned;
  logic         m_axis_discontinue;

  in_beat_t  inq[$];
  out_beat_t expq[$];
  int        exp_tails;
  int        n_cmp = 0;
  int        n_bad = 0;

  always #5 clk = ~clk;

  rc_cpl_realign_x8 dut (
    .user_clk(clk), .user_reset(user_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_hdr(m_axis_hdr),
    .m_axis_poisoned(m_axis_poisoned), .m_axis_discontinue(m_axis_discontinue)
  );

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dwkeep(input int c);
    logic [63:0] t;
    t = (64'd1 << (4*c)) - 64'd1;
    return t[31:0];
  endfunction

  // Builds the input beats of one completion and the payload beats it must yield.
  task automatic add_pkt(input int len, input int pois_beat, input int disc_beat);
    logic [31:0] pl[$];
    logic [95:0] hdr;
    in_beat_t    ib;
    out_beat_t   ob;
    int nb, idx, cnt, c;
    hdr = {$urandom, $urandom, $urandom};
    for (int i = 0; i < len; i++) pl.push_back($urandom);
    nb  = (len <= 5) ? 1 : 1 + (len - 5 + 7) / 8;
    idx = 0;
    cnt = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 8; k++) ib.data[32*k +: 32] = $urandom;
      cnt = 0;
      if (b == 0) begin
        ib.data[95:0] = hdr;
        cnt = 3;
      end
      while (cnt < 8 && idx < len) begin
        ib.data[32*cnt +: 32] = pl[idx];
        idx++;
        cnt++;
      end
      ib.keep    = dwkeep(cnt);
      ib.last    = (b == nb - 1);
      ib.user    = 85'({$urandom, $urandom, $urandom});
      ib.user[1] = (b == pois_beat);
      ib.user[0] = (b == disc_beat);
      inq.push_back(ib);
    end
    if (nb > 1 && cnt > 3) exp_tails++;
    ob.hdr  = hdr;
    ob.pois = (pois_beat >= 0 && pois_beat < nb);
    ob.disc = (disc_beat >= 0 && disc_beat < nb);
    if (len == 0) begin
      ob.data = '0;
      ob.keep = '0;
      ob.last = 1'b1;
      expq.push_back(ob);
    end else begin
      for (int s = 0; s < len; s += 8) begin
        c = (len - s < 8) ? len - s : 8;
        ob.data = '0;
        for (int k = 0; k < c; k++) ob.data[32*k +: 32] = pl[s + k];
        ob.keep = dwkeep(c);
        ob.last = (s + 8 >= len);
        expq.push_back(ob);
      end
    end
  endtask

  task automatic drive(input in_beat_t b);
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = b.last;
    s_axis_tuser  = b.user;
    s_axis_tvalid = 1'b1;
  endtask

  // Entered and left at posedge+1; inputs change only there, outputs sampled at negedge.
  task automatic run_phase(input int rdy_pct, input int vld_pct, output int low_cnt);
    int           cyc;
    logic         stall_prev, acc;
    logic [255:0] held_d;
    logic [31:0]  held_k;
    logic         held_l;
    out_beat_t    ob;
    cyc = 0;
    low_cnt = 0;
    stall_prev = 1'b0;
    held_d = '0;
    held_k = '0;
    held_l = 1'b0;
    while ((inq.size() > 0 || expq.size() > 0 || s_axis_tvalid) && cyc < 20000) begin
      if (!s_axis_tvalid && inq.size() > 0 && $urandom_range(99) < vld_pct)
        drive(inq.pop_front());
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (!s_axis_tready[0]) low_cnt++;
      if (stall_prev) begin
        chk_eq("stable_data", m_axis_tdata, held_d);
        chk_eq("stable_keep", 256'(m_axis_tkeep), 256'(held_k));
        chk_eq("stable_last", 256'(m_axis_tlast), 256'(held_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) chk_eq("extra_beat", 256'(m_axis_tkeep), 256'hDEAD);
        else begin
          ob = expq.pop_front();
          chk_eq("data", m_axis_tdata, ob.data);
          chk_eq("keep", 256'(m_axis_tkeep), 256'(ob.keep));
          chk_eq("last", 256'(m_axis_tlast), 256'(ob.last));
          chk_eq("hdr", 256'(m_axis_hdr), 256'(ob.hdr));
          if (ob.last) begin
            chk_eq("poisoned", 256'(m_axis_poisoned), 256'(ob.pois));
            chk_eq("discontinue", 256'(m_axis_discontinue), 256'(ob.disc));
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      held_k = m_axis_tkeep;
      held_l = m_axis_tlast;
      acc = s_axis_tvalid && s_axis_tready[0];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) s_axis_tvalid = 1'b0;
    end
    if (cyc >= 20000) chk_eq("timeout_pending", 256'(inq.size() + expq.size()), 256'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_tvalid"}, 256'(m_axis_tvalid), 256'd0);
    chk_eq({tag, "_tdata"}, m_axis_tdata, 256'd0);
    chk_eq({tag, "_tkeep"}, 256'(m_axis_tkeep), 256'd0);
    chk_eq({tag, "_tlast"}, 256'(m_axis_tlast), 256'd0);
    chk_eq({tag, "_hdr"}, 256'(m_axis_hdr), 256'd0);
    chk_eq({tag, "_flags"}, 256'({m_axis_poisoned, m_axis_discontinue}), 256'd0);
    chk_eq({tag, "_tready"}, 256'(s_axis_tready), 256'hF);
  endtask

  initial begin
    int low, tails0;
    user_reset    = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    exp_tails     = 0;
    repeat (3) @(posedge clk);
    #1;
    user_reset = 1'b0;
    chk_reset_outputs("por");

    // Directed shapes with a free-flowing sink: tail bubbles are exactly countable.
    add_pkt(2, -1, -1);
    add_pkt(0, 0, -1);
    add_pkt(16, -1, -1);
    add_pkt(20, -1, -1);
    add_pkt(5, -1, 0);
    run_phase(100, 100, low);
    chk_eq("tail_stalls", 256'(low), 256'(exp_tails));

    // Back-to-back packets, poison on the middle beat of the second, random backpressure.
    add_pkt(10, -1, -1);
    add_pkt(14, 1, -1);
    add_pkt(7, -1, -1);
    run_phase(50, 100, low);

    for (int p = 0; p < 40; p++)
      add_pkt($urandom_range(0, 40),
              ($urandom_range(3) == 0) ? $urandom_range(0, 5) : -1,
              ($urandom_range(5) == 0) ? $urandom_range(0, 5) : -1);
    run_phase(60, 80, low);

    tails0 = exp_tails;
    for (int p = 0; p < 10; p++) add_pkt($urandom_range(6, 40), -1, -1);
    run_phase(100, 100, low);
    chk_eq("tail_stalls_rand", 256'(low), 256'(exp_tails - tails0));

    // Reset in the middle of a packet while in the body state.
    m_axis_tready = 1'b1;
    add_pkt(20, 0, 0);
    drive(inq.pop_front());
    @(posedge clk);
    #1;
    drive(inq.pop_front());
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    chk_eq("pre_rst_tvalid", 256'(m_axis_tvalid), 256'd1);
    user_reset = 1'b1;
    @(posedge clk);
    #1;
    user_reset = 1'b0;
    chk_reset_outputs("mid_rst");
    inq.delete();
    expq.delete();
    add_pkt(3, -1, 0);
    add_pkt(12, -1, -1);
    run_phase(100, 100, low);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
